// File: rtl/sample_generator.sv
// Monte Carlo pi sample generator.
// Issues pseudo-random (x,y) points from two 32-bit Fibonacci LFSRs, one per
// cycle, and classifies each point as inside (hit) or outside (miss) the
// quarter circle of radius 2^COORD_W through a 3-stage square/sum/compare
// pipeline.
//
// Stream semantics: dout_valid is a valid-only strobe with no ready. The
// consumer must take dout on every cycle dout_valid is high; dout is held at 0
// whenever dout_valid is low. busy covers the whole run, from the cycle after
// an accepted start through the cycle carrying the last dout_valid, and falls
// together with the one-cycle done pulse.
module sample_generator #(
    parameter int          COORD_W = 16,
    parameter logic [31:0] SEED_X  = 32'hACE1_2468,
    parameter logic [31:0] SEED_Y  = 32'h1357_BDF0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] sample_count,
    input  logic        lfsr_load,
    input  logic [31:0] seed_x,
    input  logic [31:0] seed_y,
    output logic        busy,
    output logic        dout,
    output logic        dout_valid,
    output logic        done,
    output logic [1:0]  o_dbg_state
);

    localparam int SQ_W  = 2 * COORD_W;
    localparam int SUM_W = 2 * COORD_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t             r_state;
    logic [31:0]        r_remaining;
    logic [31:0]        r_lfsr_x;
    logic [31:0]        r_lfsr_y;
    logic               r_busy;
    logic               r_done;

    logic [COORD_W-1:0] r_s1_x;
    logic [COORD_W-1:0] r_s1_y;
    logic               r_s1_valid;
    logic [SQ_W-1:0]    r_s2_xx;
    logic [SQ_W-1:0]    r_s2_yy;
    logic               r_s2_valid;
    logic               r_dout;
    logic               r_dout_valid;

    logic               w_issue;
    logic [31:0]        w_lfsr_x_next;
    logic [31:0]        w_lfsr_y_next;
    logic [31:0]        w_seed_x;
    logic [31:0]        w_seed_y;
    logic [SQ_W-1:0]    w_x_ext;
    logic [SQ_W-1:0]    w_y_ext;
    logic [SUM_W-1:0]   w_sum;
    logic               w_pipe_empty;

    // A point is issued on every cycle spent in ISSUE.
    assign w_issue = (r_state == ST_ISSUE);

    // Taps 32,22,2,1: shift left, XOR of bits 31,21,1,0 enters at bit 0.
    assign w_lfsr_x_next = {r_lfsr_x[30:0], r_lfsr_x[31] ^ r_lfsr_x[21] ^ r_lfsr_x[1] ^ r_lfsr_x[0]};
    assign w_lfsr_y_next = {r_lfsr_y[30:0], r_lfsr_y[31] ^ r_lfsr_y[21] ^ r_lfsr_y[1] ^ r_lfsr_y[0]};

    // A zero seed would lock the LFSR, so it falls back to the default seed.
    assign w_seed_x = (seed_x == 32'd0) ? SEED_X : seed_x;
    assign w_seed_y = (seed_y == 32'd0) ? SEED_Y : seed_y;

    // Zero-extend so the products are computed at full 2*COORD_W width.
    assign w_x_ext = {{COORD_W{1'b0}}, r_s1_x};
    assign w_y_ext = {{COORD_W{1'b0}}, r_s1_y};

    // One extra bit keeps the carry; it is set exactly when sum >= 2^(2*COORD_W).
    assign w_sum = {1'b0, r_s2_xx} + {1'b0, r_s2_yy};

    // S3 never needs to be empty for done: done lands the cycle after the last valid.
    assign w_pipe_empty = ~r_s1_valid & ~r_s2_valid;

    // Control FSM: run acceptance, issue counting, drain, done pulse, LFSR state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_remaining <= 32'd0;
            r_lfsr_x    <= SEED_X;
            r_lfsr_y    <= SEED_Y;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_remaining <= sample_count;
                        r_busy      <= 1'b1;
                        r_state     <= (sample_count != 32'd0) ? ST_ISSUE : ST_DRAIN;
                    end else if (lfsr_load) begin
                        r_lfsr_x <= w_seed_x;
                        r_lfsr_y <= w_seed_y;
                    end
                end
                ST_ISSUE: begin
                    r_lfsr_x    <= w_lfsr_x_next;
                    r_lfsr_y    <= w_lfsr_y_next;
                    r_remaining <= r_remaining - 32'd1;
                    if (r_remaining == 32'd1) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (w_pipe_empty) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Three-stage classify pipeline: capture point, square, sum and compare.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_x       <= '0;
            r_s1_y       <= '0;
            r_s1_valid   <= 1'b0;
            r_s2_xx      <= '0;
            r_s2_yy      <= '0;
            r_s2_valid   <= 1'b0;
            r_dout       <= 1'b0;
            r_dout_valid <= 1'b0;
        end else begin
            r_s1_x       <= r_lfsr_x[COORD_W-1:0];
            r_s1_y       <= r_lfsr_y[COORD_W-1:0];
            r_s1_valid   <= w_issue;
            r_s2_xx      <= w_x_ext * w_x_ext;
            r_s2_yy      <= w_y_ext * w_y_ext;
            r_s2_valid   <= r_s1_valid;
            r_dout       <= r_s2_valid & ~w_sum[SUM_W-1];
            r_dout_valid <= r_s2_valid;
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign dout        = r_dout;
    assign dout_valid  = r_dout_valid;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_sample_generator.sv
// Testbench for sample_generator: randomized runs checked every cycle against
// a behavioural model of run timing and of the point/hit sequence. A second
// instance with COORD_W=1 shares all inputs.
module tb_sample_generator;

  localparam logic [31:0] SEED_X = 32'hACE1_2468;
  localparam logic [31:0] SEED_Y = 32'h1357_BDF0;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        lfsr_load;
  logic [31:0] sample_count;
  logic [31:0] seed_x;
  logic [31:0] seed_y;

  logic        busy, dout, dout_valid, done;
  logic [1:0]  dbg_state;
  logic        w1_busy, w1_dout, w1_dout_valid, w1_done;
  logic [1:0]  w1_dbg_state;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  sample_generator #(.COORD_W(16), .SEED_X(SEED_X), .SEED_Y(SEED_Y)) dut (
    .clk(clk), .reset(reset), .start(start), .sample_count(sample_count),
    .lfsr_load(lfsr_load), .seed_x(seed_x), .seed_y(seed_y),
    .busy(busy), .dout(dout), .dout_valid(dout_valid), .done(done),
    .o_dbg_state(dbg_state)
  );

  sample_generator #(.COORD_W(1), .SEED_X(SEED_X), .SEED_Y(SEED_Y)) dut_w1 (
    .clk(clk), .reset(reset), .start(start), .sample_count(sample_count),
    .lfsr_load(lfsr_load), .seed_x(seed_x), .seed_y(seed_y),
    .busy(w1_busy), .dout(w1_dout), .dout_valid(w1_dout_valid), .done(w1_done),
    .o_dbg_state(w1_dbg_state)
  );

  // ---------------- model state ----------------
  int checks = 0;
  int failures = 0;
  bit chk_en = 0;
  bit run_on = 0;
  int ts = 0;
  int run_n = 0;
  logic [31:0] mx, my;
  logic [1:0] exp_q[$];        // {hit at COORD_W=1, hit at COORD_W=16}
  int mdl_hits, mdl_hits1, dut_hits, dut_hits1;
  int busy_cnt, valid_cnt, done_cnt;
  logic last_dout;

  function automatic logic [31:0] lfsr_step(input logic [31:0] v);
    return (v << 1) | {31'd0, ^(v & 32'h8020_0003)};
  endfunction

  // Inside the quarter circle of radius 2^w: x^2 + y^2 < 2^(2w), strictly.
  function automatic logic model_hit(input longint x, input longint y, input int w);
    return (x * x + y * y) < (longint'(1) << (2 * w));
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- scoreboard: compare every cycle ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      int d;
      logic eb, ev, ed;
      logic [1:0] e;
      d  = cyc - ts;
      eb = run_on && ((run_n > 0) ? (d >= 1 && d <= run_n + 3) : (d == 1));
      ev = run_on && (run_n > 0) && (d >= 4) && (d <= run_n + 3);
      ed = run_on && (d == ((run_n > 0) ? run_n + 4 : 2));
      check("busy", busy, eb);
      check("dout_valid", dout_valid, ev);
      check("done", done, ed);
      check("w1_busy", w1_busy, eb);
      check("w1_dout_valid", w1_dout_valid, ev);
      check("w1_done", w1_done, ed);
      if (ev) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL queue_underflow: got valid with no expected point (cycle %0d)", cyc);
        end else begin
          e = exp_q.pop_front();
          check("dout", dout, e[0]);
          check("w1_dout", w1_dout, e[1]);
        end
      end else begin
        check("dout_idle", dout, 1'b0);
        check("w1_dout_idle", w1_dout, 1'b0);
      end
      if (dout_valid) begin
        valid_cnt++;
        last_dout = dout;
      end
      if (dout_valid && dout) dut_hits++;
      if (w1_dout_valid && w1_dout) dut_hits1++;
      if (busy) busy_cnt++;
      if (done) done_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_run(input int n);
    for (int i = 0; i < n; i++) begin
      logic h16, h1;
      h16 = model_hit(longint'(mx[15:0]), longint'(my[15:0]), 16);
      h1  = model_hit(longint'(mx[0]), longint'(my[0]), 1);
      exp_q.push_back({h1, h16});
      mdl_hits  += int'(h16);
      mdl_hits1 += int'(h1);
      mx = lfsr_step(mx);
      my = lfsr_step(my);
    end
  endtask

  task automatic clear_counts();
    mdl_hits = 0; mdl_hits1 = 0; dut_hits = 0; dut_hits1 = 0;
    busy_cnt = 0; valid_cnt = 0; done_cnt = 0;
  endtask

  // Start a run of n points; optionally pulse start/lfsr_load during the run
  // (both must be ignored) or assert lfsr_load with start (start wins).
  task automatic do_run(input int n, input bit noise, input bit load_too);
    clear_counts();
    push_run(n);
    @(posedge clk); #1;
    sample_count = n;
    start = 1'b1;
    if (load_too) begin
      lfsr_load = 1'b1;
      seed_x = 32'd5;
      seed_y = 32'd7;
    end
    ts = cyc;
    run_n = n;
    run_on = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lfsr_load = 1'b0;
    sample_count = $urandom;
    for (int i = 0; i < n + 5; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      lfsr_load = 1'b0;
      if (noise && cyc >= ts + 2 && cyc <= ts + n) begin
        start = ($urandom_range(0, 7) == 0);
        lfsr_load = ($urandom_range(0, 7) == 0);
        seed_x = $urandom;
        seed_y = $urandom;
      end
    end
    start = 1'b0;
    lfsr_load = 1'b0;
    check("queue_drained", exp_q.size(), 0);
    check("valid_count", valid_cnt, n);
    check("done_count", done_cnt, 1);
    check("busy_window", busy_cnt, (n == 0) ? 1 : n + 3);
    check("hits_w16", dut_hits, mdl_hits);
    check("hits_w1", dut_hits1, mdl_hits1);
    check("idle_state", dbg_state, 2'd0);
  endtask

  task automatic load_seeds(input logic [31:0] sx, input logic [31:0] sy);
    @(posedge clk); #1;
    lfsr_load = 1'b1;
    seed_x = sx;
    seed_y = sy;
    @(posedge clk); #1;
    lfsr_load = 1'b0;
    mx = (sx == 32'd0) ? SEED_X : sx;
    my = (sy == 32'd0) ? SEED_Y : sy;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int pi_x10k;
    reset = 1'b1; start = 1'b0; lfsr_load = 1'b0;
    sample_count = 32'd0; seed_x = 32'd0; seed_y = 32'd0;
    mx = SEED_X; my = SEED_Y;
    clear_counts();
    repeat (3) @(posedge clk);
    #1;
    chk_en = 1'b1;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_valid", dout_valid, 1'b0);
    check("rst_dout", dout, 1'b0);
    check("rst_state", dbg_state, 2'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Hand-computed pins on the model itself.
    check("pin_lfsr_1", lfsr_step(32'd1), 32'd3);
    check("pin_lfsr_3", lfsr_step(32'd3), 32'd6);
    check("pin_lfsr_msb", lfsr_step(32'h8000_0000), 32'd1);
    check("pin_hit_seed0", model_hit(64'h2468, 64'hBDF0, 16), 1'b1);
    check("pin_miss_max", model_hit(64'hFFFF, 64'hFFFF, 16), 1'b0);
    check("pin_hit_w1_01", model_hit(0, 1, 1), 1'b1);
    check("pin_hit_edge", model_hit(0, 3, 2), 1'b1);
    check("pin_miss_edge", model_hit(0, 4, 2), 1'b0);

    // N=1: seed point (0x2468, 0xBDF0) sums to 2451155776 < 2^32, a hit.
    do_run(1, 1'b0, 1'b0);
    check("n1_dout_literal", last_dout, 1'b1);

    // N=1000 with start/lfsr_load noise during the run.
    do_run(1000, 1'b1, 1'b0);

    // N=0 then a short run: LFSR state must not have moved.
    do_run(0, 1'b0, 1'b0);
    do_run(5, 1'b0, 1'b0);

    // Runtime seeds of 1, then zero seeds falling back to defaults.
    load_seeds(32'd1, 32'd1);
    do_run(64, 1'b0, 1'b0);
    load_seeds(32'd0, 32'd0);
    do_run(10, 1'b0, 1'b0);

    // Reset at the 500th valid of an N=1000 run aborts it.
    clear_counts();
    push_run(1000);
    @(posedge clk); #1;
    sample_count = 32'd1000;
    start = 1'b1;
    ts = cyc;
    run_n = 1000;
    run_on = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (502) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    run_on = 1'b0;
    exp_q.delete();
    mx = SEED_X;
    my = SEED_Y;
    check("abort_busy", busy, 1'b0);
    check("abort_valid", dout_valid, 1'b0);
    check("abort_done", done, 1'b0);
    repeat (5) begin
      @(posedge clk); #1;
    end
    check("abort_valid_count", valid_cnt, 500);
    check("abort_no_done", done_cnt, 0);

    // Fresh run after abort, with lfsr_load asserted alongside start.
    do_run(10, 1'b0, 1'b1);

    // Statistical run: hit ratio near pi/4.
    do_run(20000, 1'b0, 1'b0);
    pi_x10k = (dut_hits * 10000) / 20000;
    check("pi_ratio_in_range", (pi_x10k >= 7704 && pi_x10k <= 8004), 1'b1);

    repeat (3) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
